// File: rtl/gpio_input_filter.sv
// Per-pin GPIO input conditioning: two-flop synchroniser, prescaled debounce and rise/fall pulses.
// Define GPIO_INPUT_FILTER_GLITCH_CNT_EN to build the saturating rejected-glitch counter.
module gpio_input_filter #(
  parameter int width      = 12,
  parameter int presc_bits = 16,
  parameter int stable_cnt = 4
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic [width-1:0]      i_pad,
  input  logic [presc_bits-1:0] i_presc,
  input  logic                  i_bypass,
  output logic [width-1:0]      o_gpio,
  output logic [width-1:0]      o_rise,
  output logic [width-1:0]      o_fall,
  output logic [7:0]            o_glitch_cnt
);

  localparam int cw = $clog2(stable_cnt + 1);
  localparam logic [cw-1:0] last_cnt = cw'(stable_cnt - 1);

  logic [width-1:0]          sync1;
  logic [width-1:0]          sync2;
  logic [presc_bits-1:0]     presc_cnt;
  logic                      tick;
  logic [width-1:0][cw-1:0]  cnt;
  logic [width-1:0][cw-1:0]  cnt_next;
  logic [width-1:0]          gpio_next;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_pad;
      sync2 <= sync1;
    end
  end

  // A new i_presc value is only picked up when the counter reloads.
  assign tick = (presc_cnt == '0);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= i_presc;
    end else begin
      presc_cnt <= presc_cnt - 1'b1;
    end
  end

  always_comb begin
    gpio_next = o_gpio;
    cnt_next  = '0;
    for (int b = 0; b < width; b++) begin
      if (i_bypass) begin
        gpio_next[b] = sync2[b];
      end else if (sync2[b] != o_gpio[b]) begin
        if (tick) begin
          if (cnt[b] == last_cnt) begin
            gpio_next[b] = sync2[b];
          end else begin
            cnt_next[b] = cnt[b] + 1'b1;
          end
        end else begin
          cnt_next[b] = cnt[b];
        end
      end
    end
  end

  // Edge pulses compare the accepted next level against the current one.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_gpio <= '0;
      o_rise <= '0;
      o_fall <= '0;
      cnt    <= '0;
    end else begin
      o_gpio <= gpio_next;
      o_rise <= gpio_next & ~o_gpio;
      o_fall <= ~gpio_next & o_gpio;
      cnt    <= cnt_next;
    end
  end

`ifdef GPIO_INPUT_FILTER_GLITCH_CNT_EN
  logic [width-1:0] glitch;

  // A glitch is a partially counted mismatch that disappears before acceptance.
  always_comb begin
    glitch = '0;
    for (int b = 0; b < width; b++) begin
      glitch[b] = !i_bypass && (sync2[b] == o_gpio[b]) && (cnt[b] != '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_glitch_cnt <= 8'h00;
    end else if ((|glitch) && (o_glitch_cnt != 8'hFF)) begin
      o_glitch_cnt <= o_glitch_cnt + 8'h01;
    end
  end
`else
  assign o_glitch_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_gpio_input_filter.sv
// Self-checking bench for gpio_input_filter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the pin filter.
module tb_gpio_input_filter;

  localparam int W  = 12;
  localparam int PB = 16;
  localparam int SC = 4;

  logic          i_clk;
  logic          i_nrst;
  logic [W-1:0]  i_pad;
  logic [PB-1:0] i_presc;
  logic          i_bypass;
  logic [W-1:0]  o_gpio;
  logic [W-1:0]  o_rise;
  logic [W-1:0]  o_fall;
  logic [7:0]    o_glitch_cnt;

  int checks = 0;
  int errors = 0;

  gpio_input_filter #(.width(W), .presc_bits(PB), .stable_cnt(SC)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_pad(i_pad), .i_presc(i_presc),
    .i_bypass(i_bypass), .o_gpio(o_gpio), .o_rise(o_rise), .o_fall(o_fall),
    .o_glitch_cnt(o_glitch_cnt)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural model: pad history, reload-style tick timer, per-pin run lengths
  logic [W-1:0] m_s1, m_s2, m_gpio, m_rise, m_fall;
  int m_run[W];
  int m_wait;
  int m_glitch;

  function automatic logic [7:0] exp_glitch(input int n);
`ifdef GPIO_INPUT_FILTER_GLITCH_CNT_EN
    return (n > 255) ? 8'hFF : n[7:0];
`else
    return (n >= 0) ? 8'h00 : 8'h00;
`endif
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_gpio = '0; m_rise = '0; m_fall = '0;
    for (int b = 0; b < W; b++) m_run[b] = 0;
    m_wait = 0;
    m_glitch = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] ng;
    bit any_glitch;
    bit tk;
    tk = (m_wait == 0);
    ng = m_gpio;
    any_glitch = 0;
    for (int b = 0; b < W; b++) begin
      if (i_bypass) begin
        ng[b] = m_s2[b];
        m_run[b] = 0;
      end else if (m_s2[b] == m_gpio[b]) begin
        if (m_run[b] != 0) any_glitch = 1;
        m_run[b] = 0;
      end else if (tk) begin
        m_run[b] = m_run[b] + 1;
        if (m_run[b] >= SC) begin
          ng[b] = m_s2[b];
          m_run[b] = 0;
        end
      end
    end
    if (any_glitch) m_glitch = m_glitch + 1;
    m_wait = tk ? int'(i_presc) : m_wait - 1;
    m_rise = ng & ~m_gpio;
    m_fall = m_gpio & ~ng;
    m_gpio = ng;
    m_s2 = m_s1;
    m_s1 = i_pad;
  endtask

  // driver tasks
  task automatic step();
    @(posedge i_clk);
    if (i_nrst) model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_nrst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    model_reset();
    i_nrst = 1'b1;
  endtask

  task automatic test_reset();
    i_pad = 12'hFFF; i_presc = '0; i_bypass = 1'b1;
    @(posedge i_clk); #1;
    i_nrst = 1'b0;
    #1;
    checks++;
    if (o_gpio !== '0 || o_rise !== '0 || o_fall !== '0 || o_glitch_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got gpio=%h rise=%h fall=%h gc=%h, required all 0",
               o_gpio, o_rise, o_fall, o_glitch_cnt);
    end
    i_pad = '0; i_bypass = 1'b0;
    do_reset();
  endtask

  task automatic test_latency();
    do_reset();
    i_pad = '0; i_presc = '0; i_bypass = 1'b0;
    repeat (3) step();
    i_pad[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      checks++;
      if (o_gpio[0] !== (e >= 6) || o_rise[0] !== (e == 6) || o_fall !== '0) begin
        errors++;
        $display("FAIL latency edge=%0d got gpio0=%b rise0=%b fall=%h, required gpio0=%b rise0=%b fall=0",
                 e, o_gpio[0], o_rise[0], o_fall, (e >= 6), (e == 6));
      end
    end
  endtask

  task automatic test_glitch_reject();
    do_reset();
    i_pad = '0; i_presc = '0; i_bypass = 1'b0;
    repeat (3) step();
    i_pad[3] = 1'b1;
    repeat (3) step();
    i_pad[3] = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      checks++;
      if (o_gpio !== '0 || o_rise !== '0 || o_fall !== '0) begin
        errors++;
        $display("FAIL glitch_reject cyc=%0d got gpio=%h rise=%h fall=%h, required 0", e, o_gpio, o_rise, o_fall);
      end
    end
    checks++;
    if (o_glitch_cnt !== exp_glitch(1)) begin
      errors++;
      $display("FAIL glitch_count got %h required %h", o_glitch_cnt, exp_glitch(1));
    end
  endtask

  task automatic test_prescaled_fall();
    int cyc;
    int falls;
    bit done;
    do_reset();
    i_presc = '0; i_bypass = 1'b1; i_pad = 12'h002;
    repeat (4) step();
    i_bypass = 1'b0;
    i_presc = 16'd9;
    repeat (3) step();
    i_pad[1] = 1'b0;
    cyc = 0; falls = 0; done = 0;
    while (!done && cyc < 60) begin
      step();
      cyc++;
      if (o_fall[1]) falls++;
      if (o_gpio[1] === 1'b0) done = 1;
    end
    repeat (3) begin
      step();
      if (o_fall[1]) falls++;
    end
    checks++;
    if (!done || cyc > 52) begin
      errors++;
      $display("FAIL presc_fall_time got %0d cycles (done=%0d), required <= 52", cyc, done);
    end
    checks++;
    if (falls != 1) begin
      errors++;
      $display("FAIL presc_fall_pulses got %0d required 1", falls);
    end
    checks++;
    if (o_gpio !== m_gpio) begin
      errors++;
      $display("FAIL presc_model got %h required %h", o_gpio, m_gpio);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    i_presc = '0; i_bypass = 1'b1; i_pad = 12'hA5A;
    repeat (5) step();
    i_pad = 12'h5A5;
    repeat (2) step();
    checks++;
    if (o_gpio !== 12'hA5A) begin
      errors++;
      $display("FAIL bypass_early got %h required a5a", o_gpio);
    end
    step();
    checks++;
    if (o_gpio !== 12'h5A5 || o_rise !== 12'h5A5 || o_fall !== 12'hA5A) begin
      errors++;
      $display("FAIL bypass_edges got gpio=%h rise=%h fall=%h, required 5a5/5a5/a5a", o_gpio, o_rise, o_fall);
    end
    step();
    checks++;
    if (o_rise !== '0 || o_fall !== '0) begin
      errors++;
      $display("FAIL bypass_single_pulse got rise=%h fall=%h required 0", o_rise, o_fall);
    end
    i_bypass = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    i_pad = '0; i_presc = '0; i_bypass = 1'b0;
    repeat (3) step();
    i_pad = 12'h00F;
    repeat (7) step();
    i_pad[0] = 1'b0;
    repeat (3) step();
    #2;
    i_nrst = 1'b0;
    #1;
    checks++;
    if (o_gpio !== '0 || o_rise !== '0 || o_fall !== '0 || o_glitch_cnt !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got gpio=%h rise=%h fall=%h gc=%h, required all 0",
               o_gpio, o_rise, o_fall, o_glitch_cnt);
    end
    i_pad = 12'h001;
    @(posedge i_clk);
    #1;
    model_reset();
    i_nrst = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++;
      if (o_gpio[0] !== (e == 6)) begin
        errors++;
        $display("FAIL post_reset_latency edge=%0d got %b required %b", e, o_gpio[0], (e == 6));
      end
    end
  endtask

  task automatic test_glitch_saturate();
    do_reset();
    i_pad = '0; i_presc = '0; i_bypass = 1'b0;
    repeat (3) step();
    for (int g = 0; g < 300; g++) begin
      i_pad[0] = 1'b1;
      repeat (2) step();
      i_pad[0] = 1'b0;
      repeat (4) step();
    end
    checks++;
    if (o_glitch_cnt !== exp_glitch(300) || o_gpio[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_saturate got gc=%h gpio0=%b required gc=%h gpio0=0",
               o_glitch_cnt, o_gpio[0], exp_glitch(300));
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    i_pad = '0; i_presc = '0; i_bypass = 1'b0;
    bad = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) i_presc = PB'($urandom_range(0, 3));
      if (c % 37 == 0) i_bypass = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) i_pad = i_pad ^ W'($urandom & $urandom & $urandom);
      step();
      checks++;
      if (o_gpio !== m_gpio || o_rise !== m_rise || o_fall !== m_fall ||
          o_glitch_cnt !== exp_glitch(m_glitch)) begin
        errors++;
        if (bad < 10)
          $display("FAIL random cyc=%0d got gpio=%h rise=%h fall=%h gc=%h, required %h %h %h %h",
                   c, o_gpio, o_rise, o_fall, o_glitch_cnt, m_gpio, m_rise, m_fall, exp_glitch(m_glitch));
        bad++;
      end
    end
  endtask

  initial begin
    i_nrst = 1'b0; i_pad = '0; i_presc = '0; i_bypass = 1'b0;
    model_reset();
    test_reset();
    test_latency();
    test_glitch_reject();
    test_prescaled_fall();
    test_bypass();
    test_async_reset();
    test_glitch_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
